// File: rtl/cordic_z_angle_ctrl.sv
// Z-path controller for a circular CORDIC rotator: folds the target angle into
// +/-90 degrees, then steers the residual to zero against an arctan ROM.
`timescale 1ns/1ps
module cordic_z_angle_ctrl #(
  parameter int ITER = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] z_in,
  output logic               ld,
  output logic [3:0]         i,
  output logic               delta,
  output logic               flip,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] z_res,
  output logic [1:0]         dbg_state
);

  // Handshake: start is a level request honoured only in IDLE (never queued);
  // ld and done are single-cycle strobes; i/delta are valid for the whole
  // ITER cycle and are consumed on the rising edge that ends it.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0]         LAST_I  = 4'(ITER - 1);
  localparam logic signed [15:0] QUARTER = 16'sd16384;

  state_e             state_q, state_d;
  logic [3:0]         i_q, i_d;
  logic signed [15:0] z_q, z_d;
  logic signed [15:0] z_res_q, z_res_d;
  logic               flip_q, flip_d;
  logic               need_flip;
  logic signed [15:0] atan;
  logic signed [15:0] z_step;

  function automatic logic signed [15:0] atan_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_rom = 16'sd8192;
      4'd1:    atan_rom = 16'sd4836;
      4'd2:    atan_rom = 16'sd2555;
      4'd3:    atan_rom = 16'sd1297;
      4'd4:    atan_rom = 16'sd651;
      4'd5:    atan_rom = 16'sd326;
      4'd6:    atan_rom = 16'sd163;
      4'd7:    atan_rom = 16'sd81;
      4'd8:    atan_rom = 16'sd41;
      4'd9:    atan_rom = 16'sd20;
      4'd10:   atan_rom = 16'sd10;
      4'd11:   atan_rom = 16'sd5;
      4'd12:   atan_rom = 16'sd3;
      4'd13:   atan_rom = 16'sd1;
      4'd14:   atan_rom = 16'sd1;
      default: atan_rom = 16'sd0;
    endcase
  endfunction

  // Exactly +/-16384 already converges, so only strictly larger magnitudes flip.
  assign need_flip = (z_in > QUARTER) || (z_in < -QUARTER);
  assign atan      = atan_rom(i_q);
  assign z_step    = z_q[15] ? (z_q + atan) : (z_q - atan);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= 4'd0;
      z_q     <= 16'sd0;
      z_res_q <= 16'sd0;
      flip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      z_q     <= z_d;
      z_res_q <= z_res_d;
      flip_q  <= flip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    z_d     = z_q;
    z_res_d = z_res_q;
    flip_d  = flip_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          z_d     = need_flip ? {~z_in[15], z_in[14:0]} : z_in;
          flip_d  = need_flip;
          i_d     = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_ITER;
      end
      S_ITER: begin
        z_d = z_step;
        i_d = i_q + 4'd1;
        if (i_q == LAST_I) begin
          // Capture the final residual so it is already visible in DONE.
          z_res_d = z_step;
          i_d     = 4'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ld        = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_ITER);
  assign done      = (state_q == S_DONE);
  assign delta     = (state_q == S_ITER) && z_q[15];
  assign i         = i_q;
  assign flip      = flip_q;
  assign z_res     = z_res_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cordic_z_angle_ctrl.sv
// Bench for cordic_z_angle_ctrl: directed and random rotations checked cycle by
// cycle against an integer model of the angle-folding and residual recurrence.
`timescale 1ns/1ps
module tb_cordic_z_angle_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic               start;
  logic signed [15:0] z_in;
  logic               ld, delta, flip, busy, done;
  logic [3:0]         i;
  logic signed [15:0] z_res;
  logic [1:0]         dbg_state;

  // ITER = 4 instance
  logic               start4;
  logic signed [15:0] z_in4;
  logic               ld4, delta4, flip4, busy4, done4;
  logic [3:0]         i4;
  logic signed [15:0] z_res4;
  logic [1:0]         dbg_state4;

  cordic_z_angle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .z_in(z_in),
    .ld(ld), .i(i), .delta(delta), .flip(flip), .busy(busy),
    .done(done), .z_res(z_res), .dbg_state(dbg_state)
  );

  cordic_z_angle_ctrl #(.ITER(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .z_in(z_in4),
    .ld(ld4), .i(i4), .delta(delta4), .flip(flip4), .busy(busy4),
    .done(done4), .z_res(z_res4), .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard / model ----------------
  int n_assert = 0;
  int n_fail   = 0;

  int atan_tab [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                        41, 20, 10, 5, 3, 1, 1, 0};
  bit m_d [16];
  bit m_flip;
  int m_zres;
  bit obs_d [16];
  bit d45_first [16];
  int zr;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Fold into +/-90 degrees by adding/subtracting half a turn, then run the
  // greedy residual recurrence for n steps.
  task automatic model(input int z0, input int n);
    int z;
    z      = z0;
    m_flip = 1'b0;
    if (z > 16384 || z < -16384) begin
      m_flip = 1'b1;
      z = (z > 0) ? z - 32768 : z + 32768;
    end
    for (int k = 0; k < 16; k++) m_d[k] = 1'b0;
    for (int k = 0; k < n; k++) begin
      m_d[k] = (z < 0);
      z = m_d[k] ? z + atan_tab[k] : z - atan_tab[k];
    end
    m_zres = z;
  endtask

  // ---------------- driver ----------------
  // Called one step after a rising edge with the DUT in IDLE.
  task automatic run_one(input int z, input bit chaos, input bit keep);
    model(z, 16);
    start = 1'b1;
    z_in  = z[15:0];
    @(posedge clk); #1;
    start = 1'b0;
    z_in  = 16'($urandom);
    chk("load_ld", ld, 1);
    chk("load_busy", busy, 1);
    chk("load_i", i, 0);
    chk("load_delta", delta, 0);
    chk("load_done", done, 0);
    chk("load_flip", flip, m_flip);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk("iter_i", i, k);
      chk("iter_delta", delta, m_d[k]);
      chk("iter_ld", ld, 0);
      chk("iter_busy", busy, 1);
      chk("iter_done", done, 0);
      obs_d[k] = delta;
      if (chaos) begin
        start = (k == 5) ? 1'b1 : 1'($urandom_range(0, 1));
        z_in  = (k == 5) ? 16'sd1000 : 16'($urandom);
      end
    end
    @(posedge clk); #1;
    chk("done_done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_ld", ld, 0);
    chk("done_i", i, 0);
    chk("done_delta", delta, 0);
    chk("done_zres", z_res, m_zres);
    chk("done_flip", flip, m_flip);
    start = keep;
    z_in  = 16'($urandom);
    @(posedge clk); #1;
    chk("idle_ld", ld, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_zres", z_res, m_zres);
    chk("idle_flip", flip, m_flip);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    z_in   = 16'sd0;
    start4 = 1'b0;
    z_in4  = 16'sd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld", ld, 0);
    chk("rst_i", i, 0);
    chk("rst_delta", delta, 0);
    chk("rst_flip", flip, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zres", z_res, 0);
    chk("rst4_busy", busy4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero angle
    run_one(0, 1'b0, 1'b0);
    chk("zero_d0", obs_d[0], 0);
    chk("zero_d1", obs_d[1], 1);
    chk("zero_d2", obs_d[2], 1);
    chk("zero_d3", obs_d[3], 1);
    chk("zero_d4", obs_d[4], 0);
    chk("zero_d5", obs_d[5], 1);
    chk("zero_d6", obs_d[6], 0);
    chk("zero_d7", obs_d[7], 0);
    chk("zero_zres", z_res, 0);
    chk("zero_flip", flip, 0);

    // 45 degrees, with a start pulse (z_in=1000) injected at i=5
    run_one(8192, 1'b1, 1'b0);
    chk("d45_d0", obs_d[0], 0);
    chk("d45_d1", obs_d[1], 0);
    chk("d45_d2", obs_d[2], 1);
    zr = z_res;
    chk("d45_zres_small", (zr <= 2 && zr >= -2), 1);
    for (int k = 0; k < 16; k++) d45_first[k] = obs_d[k];

    // Pre-rotation boundaries
    run_one(20000, 1'b0, 1'b0);
    chk("pre20000_flip", flip, 1);
    chk("pre20000_d0", obs_d[0], 1);
    run_one(-32768, 1'b0, 1'b0);
    chk("pre_m32768_flip", flip, 1);
    chk("pre_m32768_zres", z_res, 0);
    run_one(16384, 1'b0, 1'b0);
    chk("pre16384_flip", flip, 0);
    run_one(-16384, 1'b0, 1'b0);
    chk("pre_m16384_flip", flip, 0);
    run_one(-16385, 1'b0, 1'b0);
    chk("pre_m16385_flip", flip, 1);

    // Back-to-back: start held through DONE is ignored, taken in IDLE
    run_one(-5000, 1'b0, 1'b1);
    run_one(30000, 1'b0, 1'b0);

    // Random rotations with random start noise and back-to-back chaining
    for (int n = 0; n < 24; n++) begin
      run_one(int'($urandom_range(0, 65535)) - 32768,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;

    // Asynchronous reset in the middle of a run at i=9
    start = 1'b1;
    z_in  = 16'sd20000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    chk("midrst_pre_i", i, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ld", ld, 0);
    chk("midrst_i", i, 0);
    chk("midrst_delta", delta, 0);
    chk("midrst_flip", flip, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_zres", z_res, 0);
    @(posedge clk); #1;
    chk("midrst_hold_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_one(8192, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) chk("replay45_d", obs_d[k], d45_first[k]);

    // ITER = 4 instance
    model(0, 4);
    start4 = 1'b1;
    z_in4  = 16'sd0;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("it4_load_ld", ld4, 1);
    chk("it4_load_i", i4, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("it4_i", i4, k);
      chk("it4_delta", delta4, m_d[k]);
      chk("it4_busy", busy4, 1);
    end
    @(posedge clk); #1;
    chk("it4_done", done4, 1);
    chk("it4_zres", z_res4, 496);
    chk("it4_zres_model", z_res4, m_zres);
    @(posedge clk); #1;
    chk("it4_idle_done", done4, 0);
    chk("it4_idle_busy", busy4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_z_angle_ctrl.md
# cordic_z_angle_ctrl

Angle-path controller for the circular CORDIC rotator. It sits directly upstream of the X/Y shift-add datapath and generates that datapath's load pulse, iteration index `i` and per-iteration direction `delta`. It does this by running the Z residual-angle accumulator against an arctangent ROM. It also performs ±180° quadrant pre-rotation so the full binary-angle range converges.

## Interface
Parameters:
- `ITER`, default 16: number of micro-rotations, legal range 1..16.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `start`, input, 1: request a rotation; sampled only in IDLE.
- `z_in`, input, 16, signed: target angle in binary-angle units (1 LSB = 2π/65536, so 16384 = 90°).
- `ld`, output, 1: one-cycle load strobe to the X/Y datapath.
- `i`, output, 4: current iteration index (shift amount).
- `delta`, output, 1: rotation direction for index `i`; 1 = residual negative (rotate clockwise).
- `flip`, output, 1: 1 = input was pre-rotated by 180°; downstream negates its initial X/Y.
- `busy`, output, 1: high from LOAD through the last ITER cycle.
- `done`, output, 1: one-cycle completion pulse.
- `z_res`, output, 16, signed: final residual angle; held until the next accepted start.

## Operation
- States: IDLE → LOAD → ITER → DONE → IDLE.
- **IDLE:** `start` = 1 latches `z_in` into `z_reg` with pre-rotation and moves to LOAD.
  - If `z_in` > 16384 or `z_in` < -16384, `z_reg` = `z_in` with MSB inverted (±180°) and `flip` = 1.
  - Otherwise `z_reg` = `z_in` and `flip` = 0.
  - Exactly ±16384 is not flipped. -32768 maps to 0 with `flip` = 1.
- **LOAD:** `ld` = 1, `i` = 0, `busy` = 1. Next state is ITER.
- **ITER:**
  - `delta` = `z_reg[15]` (combinational from the register).
  - Each cycle, `z_reg` ← `delta` ? `z_reg` + `ATAN[i]` : `z_reg` − `ATAN[i]`, and `i` ← `i` + 1.
  - After the cycle with `i` = `ITER`−1, next state is DONE.
- **DONE:** `done` = 1, `busy` = 0, `z_res` = `z_reg`. Next state is IDLE.
- **ATAN ROM,** `i` = 0..15: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- **Arithmetic:** 16-bit two's-complement. After pre-rotation |`z_reg`| ≤ 16384 and the worst-case excursion stays below 18200, so no overflow handling is required.
- **Start while busy:** ignored, never queued. `start` in the DONE cycle is also ignored.
- **`z_in`:** used only in the accept cycle; later changes have no effect.
- **Reset values,** also applied on reset mid-operation: state IDLE; `ld`, `delta`, `flip`, `busy` and `done` = 0; `i` = 0; `z_reg` and `z_res` = 0. The downstream datapath must be reloaded after reset.
- **Outside ITER:** `delta` = 0. `i` holds 0 in IDLE and LOAD.

## Timing
- Edge 0 accepts `start`. The LOAD cycle occupies the next clock period.
- ITER cycles follow, `ITER` of them, with `i` = 0..`ITER`−1. The downstream stage samples `i`/`delta` on the rising edge ending each cycle.
- `done` is asserted `ITER` + 2 cycles after the accept edge: 18 cycles for the default.
- Back-to-back: a new `start` is accepted in the IDLE cycle after DONE, giving a minimum period of `ITER` + 3 cycles.
- `ld` and `done` are exactly one cycle wide and are never high together.
- `flip` is valid from LOAD and held until the next accept.

## Test plan
- **Zero angle:** `z_in` = 0, `start` pulse.
  - Expect `ld` high 1 cycle, then `delta` for `i` = 0..7 = 0,1,1,1,0,1,0,0.
  - Expect `done` 18 cycles after accept, `z_res` = 0, `flip` = 0.
- **45°:** `z_in` = 8192.
  - Expect `delta` = 0,0,1 at `i` = 0,1,2, with `z_reg` = 0 after `i` = 0 and -4836 after `i` = 1.
  - Expect |`z_res`| ≤ 2.
- **Pre-rotation:** `z_in` = 20000 → `flip` = 1, first `z_reg` = -12768, `delta`(`i` = 0) = 1.
  - `z_in` = -32768 → `flip` = 1, `z_reg` = 0.
  - `z_in` = 16384 → `flip` = 0.
- **Busy protection:** assert `start` with `z_in` = 1000 at `i` = 5 during a run.
  - Expect no restart and the `i` sequence uninterrupted.
  - The next start is accepted only after `done`.
- **Reset mid-operation:** drop `rst_n` asynchronously at `i` = 9.
  - Expect all outputs to go to 0 immediately, without waiting for a clock edge.
  - After release, a fresh `start` with `z_in` = 8192 reproduces the 45° sequence exactly.
- **Parameter `ITER` = 4:** `z_in` = 0 → `i` = 0..3 only, `done` 6 cycles after accept, `z_res` = 496.
